// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and sizing helpers for the PWM generator
package pwm_pkg;

    localparam int DUTY_W = 4;
    localparam int STEPS  = 16;

    typedef logic [DUTY_W-1:0] duty_t;

    function automatic int pre_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pwm_generator_if.sv
// rtl/pwm_generator_if.sv - control and output bundle between duty controller, PWM block and pin
interface pwm_generator_if;
    import pwm_pkg::*;

    logic  en;
    duty_t duty_cycle;
    logic  pwm_out;
    logic  period_start;
    duty_t duty_active;

    modport master (
        output en,
        output duty_cycle,
        input  pwm_out,
        input  period_start,
        input  duty_active
    );

    modport slave (
        input  en,
        input  duty_cycle,
        output pwm_out,
        output period_start,
        output duty_active
    );

endinterface

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - step-rate divider; tick marks the last clock of each step
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 3125
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic at_start
);

    localparam int PRE_W = pre_width(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    assign tick     = !clr && (pre_cnt_q == PRE_MAX);
    assign at_start = (pre_cnt_q == '0);

    always_comb begin
        pre_cnt_d = pre_cnt_q + 1'b1;
        if (clr || tick) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - 16-step PWM with a shadowed duty word loaded only at period wrap
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 3125
) (
    input  logic            clk,
    input  logic            rst,
    pwm_generator_if.slave  bus_if
);

    localparam logic [DUTY_W-1:0] LAST_STEP = DUTY_W'(STEPS - 1);

    logic  tick;
    logic  pre_at_start;

    logic [DUTY_W-1:0] step_q;
    duty_t             shadow_q;
    logic              pwm_q;
    logic              period_start_q;
    duty_t             duty_active_q;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (!bus_if.en),
        .tick     (tick),
        .at_start (pre_at_start)
    );

    // Outputs are computed from the pre-update counters, so they trail state by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q         <= '0;
            shadow_q       <= '0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            duty_active_q  <= '0;
        end else begin
            duty_active_q <= shadow_q;
            if (!bus_if.en) begin
                step_q         <= '0;
                shadow_q       <= bus_if.duty_cycle;
                pwm_q          <= 1'b0;
                period_start_q <= 1'b0;
            end else begin
                pwm_q          <= (step_q < shadow_q);
                period_start_q <= (step_q == '0) && pre_at_start;
                if (tick) begin
                    step_q <= step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        shadow_q <= bus_if.duty_cycle;
                    end
                end
            end
        end
    end

    assign bus_if.pwm_out      = pwm_q;
    assign bus_if.period_start = period_start_q;
    assign bus_if.duty_active  = duty_active_q;

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Converts the 4-bit duty-cycle word from the up/down duty controller into a PWM waveform with a fixed period of 16 steps, each step PRESCALE clocks long. Duty word d gives d/16 high time, in 6.25% increments. A shadow register samples the duty word only at period boundaries, so a change on the input never produces a runt pulse. The block sits between the duty controller and the output pin.

## Interface
- PRESCALE, default 3125: clocks per step, ≥1. At 50 MHz the PWM runs at 1 kHz.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable. Level-sensitive.
- duty_cycle  in  4  requested duty in steps, 0..15.
- pwm_out  out  1  PWM output, registered.
- period_start  out  1  one-clock pulse, aligned with the first pwm_out cycle of each period.
- duty_active  out  4  shadow duty currently applied.

## Operation
**Internal state**
- pre_cnt: 0..PRESCALE-1.
- step: 0..15.
- shadow: 4 bits.
- tick = en && (pre_cnt == PRESCALE-1).

**Reset (rst=1, async)**
- pre_cnt, step, shadow, pwm_out, period_start and duty_active all go to 0.

**en=0**
- Each clock: pre_cnt←0, step←0, shadow←duty_cycle.
- pwm_out←0, period_start←0.
- The shadow tracks the input, so the first period after enable uses the current duty.

**en=1**
- pre_cnt increments and wraps to 0 on tick.
- On tick, step increments, wrapping 15→0.
- On tick with step==15, shadow←duty_cycle. This is the only update point while enabled.
- pwm_out←(step < shadow), evaluated on the pre-update registers.
- period_start←(step==0 && pre_cnt==0).

**Duty mapping**
- 0: constant low.
- d in 1..15: high for d×PRESCALE clocks, then low for (16−d)×PRESCALE clocks.
- 100% is not reachable; this matches the controller's 0..15 range.

**Boundary conditions**
- duty_cycle changes mid-period: the current period is unaffected.
- duty_cycle changes in the same clock as the wrap tick: the new value is captured.
- en falls mid-period: pwm_out goes low on the next clock, and the counters clear.
- en rises: period_start and the first high cycle follow one clock later (d>0).
- rst mid-period: all outputs are 0 immediately. After release, behaviour is identical to a fresh enable.
- The compare is unsigned 4-bit. No arithmetic overflow is possible, because step wraps explicitly.

## Timing
- Period: exactly 16×PRESCALE clocks, constant regardless of duty.
- Latency: pwm_out and period_start lag internal state by 1 clock. The two are mutually aligned.
- Duty change to output: takes effect at the next period boundary, up to 16×PRESCALE clocks later.
- duty_active reflects shadow with the same 1-clock lag as pwm_out.
- No handshake. duty_cycle is sampled synchronously and needs no qualifier; the controller updates it on clk.

## Structure
**Package pwm_pkg**
- DUTY_W=4.
- STEPS=16.
- Type for the duty word.
- Function for the prescaler width: max(1, clog2(PRESCALE)).

**Sub-module pwm_prescaler**
- Parameter PRESCALE.
- Ports: clk, rst, clr, tick.
- Holds pre_cnt. clr is driven by !en.

**Top level**
- Step counter, shadow register, compare and output registers.

## Test plan
1. PRESCALE=4, duty=4, en=1 after reset → 64-clock period; pwm_out high 16 clocks, then low 48; period_start pulses every 64 clocks, coincident with the pwm_out rising edge.
2. duty=0 → pwm_out constantly 0, period_start still every 64 clocks. duty=15 → high 60 clocks, low 4.
3. duty=4, switch to 10 at clock 5 of a period → that period high 16; next period high 40; duty_active changes to 10 at the boundary.
4. Change to 9 in the exact wrap-tick clock → the next period is high 36.
5. Drop en at clock 8 of the high phase → pwm_out 0 the next clock. Re-enable with duty=6 → period_start one clock later, high 24, full period.
6. Assert rst mid-high with PRESCALE=1, duty=12 → all outputs 0 asynchronously. After release and en=1 → 16-clock period, high 12, low 4.
